// File: rtl/multi_cycle_execute_stage2_pkg.sv
// Shared types and widths for the multi-cycle arithmetic pipeline stages.
package multi_cycle_execute_stage2_pkg;

  localparam int VECTOR_LANES   = 16;
  localparam int FP_SIG_WIDTH   = 24;
  localparam int FP_ALIGN_WIDTH = 27;
  localparam int FP_SUM_WIDTH   = 28;

  typedef logic [1:0] thread_idx_t;
  typedef logic [1:0] subcycle_t;

  typedef enum logic [1:0] {
    PIPE_MEM          = 2'd0,
    PIPE_SCYCLE_ARITH = 2'd1,
    PIPE_MCYCLE_ARITH = 2'd2
  } pipeline_sel_t;

  typedef struct packed {
    logic [7:0]    opcode;
    logic [4:0]    dest_reg;
    logic          has_dest;
    pipeline_sel_t pipeline_sel;
  } decoded_instruction_t;

endpackage

// File: rtl/multi_cycle_execute_stage2_fp_align_shift.sv
// Right-shifts the smaller significand by the exponent difference, folding
// every bit shifted past the sticky position into the sticky bit.
module fp_align_shift
  import multi_cycle_execute_stage2_pkg::*;
(
  input  logic [FP_SIG_WIDTH-1:0]   significand,
  input  logic [5:0]                shift_amount,
  output logic [FP_ALIGN_WIDTH-1:0] aligned
);

  logic [FP_ALIGN_WIDTH-1:0] extended;
  logic [FP_ALIGN_WIDTH-1:0] lost_bits;

  assign extended = {significand, 3'b000};

  // Shifts of 27 or more move everything into sticky, so only nonzero-ness survives.
  always_comb begin
    aligned   = '0;
    lost_bits = '0;
    if (shift_amount >= 6'd27) begin
      aligned = {{(FP_ALIGN_WIDTH-1){1'b0}}, |significand};
    end else begin
      aligned    = extended >> shift_amount;
      lost_bits  = extended & ((27'd1 << shift_amount) - 27'd1);
      aligned[0] = aligned[0] | (|lost_bits);
    end
  end

endmodule

// File: rtl/multi_cycle_execute_stage2.sv
// Multi-cycle FP pipeline stage 2: per-lane significand alignment and
// add/subtract, plus one-stage transport of instruction state with rollback squash.
module multi_cycle_execute_stage2
  import multi_cycle_execute_stage2_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         wb_rollback_en,
  input  thread_idx_t                                  wb_rollback_thread_idx,
  input  logic                                         mx1_instruction_valid,
  input  decoded_instruction_t                         mx1_instruction,
  input  logic [VECTOR_LANES-1:0]                      mx1_mask_value,
  input  thread_idx_t                                  mx1_thread_idx,
  input  subcycle_t                                    mx1_subcycle,
  input  logic [VECTOR_LANES-1:0][FP_SIG_WIDTH-1:0]    mx1_significand1,
  input  logic [VECTOR_LANES-1:0][FP_SIG_WIDTH-1:0]    mx1_significand2,
  input  logic [VECTOR_LANES-1:0][5:0]                 mx1_shift_amount,
  input  logic [VECTOR_LANES-1:0][7:0]                 mx1_exponent,
  input  logic [VECTOR_LANES-1:0]                      mx1_logical_subtract,
  input  logic [VECTOR_LANES-1:0]                      mx1_result_sign,
  output logic                                         mx2_instruction_valid,
  output decoded_instruction_t                         mx2_instruction,
  output logic [VECTOR_LANES-1:0]                      mx2_mask_value,
  output thread_idx_t                                  mx2_thread_idx,
  output subcycle_t                                    mx2_subcycle,
  output logic [VECTOR_LANES-1:0][FP_SUM_WIDTH-1:0]    mx2_sum,
  output logic [VECTOR_LANES-1:0][7:0]                 mx2_exponent,
  output logic [VECTOR_LANES-1:0]                      mx2_result_sign,
  output logic [VECTOR_LANES-1:0]                      mx2_logical_subtract
);

  logic [VECTOR_LANES-1:0][FP_SUM_WIDTH-1:0] lane_sum;
  logic [VECTOR_LANES-1:0]                   lane_sign;
  logic                                      squash;

  for (genvar lane = 0; lane < VECTOR_LANES; lane++) begin : gen_lane
    logic [FP_ALIGN_WIDTH-1:0] aligned;
    logic [FP_SUM_WIDTH-1:0]   ext1;
    logic [FP_SUM_WIDTH-1:0]   ext2;

    fp_align_shift u_align (
      .significand  (mx1_significand2[lane]),
      .shift_amount (mx1_shift_amount[lane]),
      .aligned      (aligned)
    );

    assign ext1 = {1'b0, mx1_significand1[lane], 3'b000};
    assign ext2 = {1'b0, aligned};

    // Stage 1 orders operands so ext1 >= ext2; subtraction never borrows out.
    assign lane_sum[lane]  = mx1_logical_subtract[lane] ? (ext1 - ext2) : (ext1 + ext2);
    // An exact cancellation rounds to +0 under round-to-nearest.
    assign lane_sign[lane] = mx1_result_sign[lane]
                           & ~(mx1_logical_subtract[lane] & (lane_sum[lane] == '0));
  end

  assign squash = wb_rollback_en && (wb_rollback_thread_idx == mx1_thread_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mx2_instruction_valid <= 1'b0;
      mx2_instruction       <= '0;
      mx2_mask_value        <= '0;
      mx2_thread_idx        <= '0;
      mx2_subcycle          <= '0;
    end else begin
      mx2_instruction_valid <= mx1_instruction_valid && !squash;
      mx2_instruction       <= mx1_instruction;
      mx2_mask_value        <= mx1_mask_value;
      mx2_thread_idx        <= mx1_thread_idx;
      mx2_subcycle          <= mx1_subcycle;
    end
  end

  // Datapath has no reset or enable; consumers qualify it with valid.
  always_ff @(posedge clk) begin
    mx2_sum              <= lane_sum;
    mx2_exponent         <= mx1_exponent;
    mx2_result_sign      <= lane_sign;
    mx2_logical_subtract <= mx1_logical_subtract;
  end

endmodule

// File: tb/tb_multi_cycle_execute_stage2.sv
// Scoreboard bench: stimulus pushes expected mx2 results, a negedge monitor
// pops and compares whenever mx2_instruction_valid is seen.
module tb_multi_cycle_execute_stage2;
  import multi_cycle_execute_stage2_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wb_rollback_en;
  thread_idx_t wb_rollback_thread_idx;
  logic mx1_instruction_valid;
  decoded_instruction_t mx1_instruction;
  logic [VECTOR_LANES-1:0] mx1_mask_value;
  thread_idx_t mx1_thread_idx;
  subcycle_t mx1_subcycle;
  logic [VECTOR_LANES-1:0][FP_SIG_WIDTH-1:0] mx1_significand1;
  logic [VECTOR_LANES-1:0][FP_SIG_WIDTH-1:0] mx1_significand2;
  logic [VECTOR_LANES-1:0][5:0] mx1_shift_amount;
  logic [VECTOR_LANES-1:0][7:0] mx1_exponent;
  logic [VECTOR_LANES-1:0] mx1_logical_subtract;
  logic [VECTOR_LANES-1:0] mx1_result_sign;
  logic mx2_instruction_valid;
  decoded_instruction_t mx2_instruction;
  logic [VECTOR_LANES-1:0] mx2_mask_value;
  thread_idx_t mx2_thread_idx;
  subcycle_t mx2_subcycle;
  logic [VECTOR_LANES-1:0][FP_SUM_WIDTH-1:0] mx2_sum;
  logic [VECTOR_LANES-1:0][7:0] mx2_exponent;
  logic [VECTOR_LANES-1:0] mx2_result_sign;
  logic [VECTOR_LANES-1:0] mx2_logical_subtract;

  typedef struct {
    decoded_instruction_t    instr;
    logic [VECTOR_LANES-1:0] mask;
    thread_idx_t             thread;
    subcycle_t               sub;
    logic [27:0]             sum;
    logic [7:0]              exponent;
    logic                    sign;
    logic                    lsub;
  } expect_t;

  expect_t scoreboard[$];
  int vectors_applied = 0;
  int miscompares = 0;
  int next_id = 1;

  multi_cycle_execute_stage2 dut (
    .clk                    (clk),
    .reset                  (reset),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .mx1_instruction_valid  (mx1_instruction_valid),
    .mx1_instruction        (mx1_instruction),
    .mx1_mask_value         (mx1_mask_value),
    .mx1_thread_idx         (mx1_thread_idx),
    .mx1_subcycle           (mx1_subcycle),
    .mx1_significand1       (mx1_significand1),
    .mx1_significand2       (mx1_significand2),
    .mx1_shift_amount       (mx1_shift_amount),
    .mx1_exponent           (mx1_exponent),
    .mx1_logical_subtract   (mx1_logical_subtract),
    .mx1_result_sign        (mx1_result_sign),
    .mx2_instruction_valid  (mx2_instruction_valid),
    .mx2_instruction        (mx2_instruction),
    .mx2_mask_value         (mx2_mask_value),
    .mx2_thread_idx         (mx2_thread_idx),
    .mx2_subcycle           (mx2_subcycle),
    .mx2_sum                (mx2_sum),
    .mx2_exponent           (mx2_exponent),
    .mx2_result_sign        (mx2_result_sign),
    .mx2_logical_subtract   (mx2_logical_subtract)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    mx1_instruction_valid  = 1'b0;
    wb_rollback_en         = 1'b0;
    wb_rollback_thread_idx = '0;
  endtask

  // Drives one vector (all lanes identical) at a negedge; pushes the expected result unless squashed.
  task automatic applyStimulus(
    input thread_idx_t thread, input logic rb_en, input thread_idx_t rb_thread,
    input logic [23:0] sig1, input logic [23:0] sig2, input logic [5:0] shift,
    input logic lsub, input logic sign,
    input logic [27:0] exp_sum, input logic exp_sign, input logic expect_valid);
    expect_t e;
    @(negedge clk);
    mx1_instruction_valid  = 1'b1;
    mx1_instruction        = '{opcode: 8'(next_id), dest_reg: 5'(next_id), has_dest: 1'b1,
                               pipeline_sel: PIPE_MCYCLE_ARITH};
    mx1_mask_value         = 16'hA5A5 ^ 16'(next_id);
    mx1_thread_idx         = thread;
    mx1_subcycle           = 2'(next_id);
    wb_rollback_en         = rb_en;
    wb_rollback_thread_idx = rb_thread;
    for (int i = 0; i < VECTOR_LANES; i++) begin
      mx1_significand1[i]     = sig1;
      mx1_significand2[i]     = sig2;
      mx1_shift_amount[i]     = shift;
      mx1_exponent[i]         = 8'(8'h70 + next_id);
      mx1_logical_subtract[i] = lsub;
      mx1_result_sign[i]      = sign;
    end
    if (expect_valid) begin
      e.instr    = mx1_instruction;
      e.mask     = mx1_mask_value;
      e.thread   = thread;
      e.sub      = mx1_subcycle;
      e.sum      = exp_sum;
      e.exponent = 8'(8'h70 + next_id);
      e.sign     = exp_sign;
      e.lsub     = lsub;
      scoreboard.push_back(e);
    end
    next_id++;
  endtask

  task automatic waitDrain();
    int cycles = 0;
    while (scoreboard.size() != 0 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    checkOutput("scoreboard_drain", 64'(scoreboard.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && mx2_instruction_valid) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_valid", 64'd1, 64'd0);
      end else begin
        expect_t e;
        e = scoreboard.pop_front();
        checkOutput("instruction", 64'(mx2_instruction), 64'(e.instr));
        checkOutput("mask", 64'(mx2_mask_value), 64'(e.mask));
        checkOutput("thread", 64'(mx2_thread_idx), 64'(e.thread));
        checkOutput("subcycle", 64'(mx2_subcycle), 64'(e.sub));
        for (int i = 0; i < VECTOR_LANES; i++) begin
          checkOutput($sformatf("sum[%0d]", i), 64'(mx2_sum[i]), 64'(e.sum));
          checkOutput($sformatf("exponent[%0d]", i), 64'(mx2_exponent[i]), 64'(e.exponent));
          checkOutput($sformatf("sign[%0d]", i), 64'(mx2_result_sign[i]), 64'(e.sign));
          checkOutput($sformatf("lsub[%0d]", i), 64'(mx2_logical_subtract[i]), 64'(e.lsub));
        end
      end
    end
  end

  initial begin
    driveIdle();
    mx1_instruction      = '0;
    mx1_mask_value       = '0;
    mx1_thread_idx       = '0;
    mx1_subcycle         = '0;
    mx1_significand1     = '0;
    mx1_significand2     = '0;
    mx1_shift_amount     = '0;
    mx1_exponent         = '0;
    mx1_logical_subtract = '0;
    mx1_result_sign      = '0;

    #1 reset = 1'b1;
    #1;
    checkOutput("reset_valid", 64'(mx2_instruction_valid), 64'd0);
    checkOutput("reset_instruction", 64'(mx2_instruction), 64'd0);
    checkOutput("reset_mask", 64'(mx2_mask_value), 64'd0);
    checkOutput("reset_thread", 64'(mx2_thread_idx), 64'd0);
    checkOutput("reset_subcycle", 64'(mx2_subcycle), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    // thread, rb_en, rb_thread, sig1, sig2, shift, lsub, sign, expected sum, expected sign, valid
    applyStimulus(2'd0, 1'b0, 2'd0, 24'h800000, 24'h800000, 6'd0,  1'b0, 1'b1, 28'h8000000, 1'b1, 1'b1);
    applyStimulus(2'd1, 1'b0, 2'd0, 24'h800000, 24'h800000, 6'd1,  1'b0, 1'b0, 28'h6000000, 1'b0, 1'b1);
    applyStimulus(2'd2, 1'b0, 2'd0, 24'h800000, 24'h800000, 6'd30, 1'b0, 1'b1, 28'h4000001, 1'b1, 1'b1);
    applyStimulus(2'd3, 1'b0, 2'd0, 24'h800000, 24'hFFFFFF, 6'd4,  1'b1, 1'b1, 28'h3800001, 1'b1, 1'b1);
    applyStimulus(2'd0, 1'b0, 2'd0, 24'hC00000, 24'hC00000, 6'd0,  1'b1, 1'b1, 28'h0000000, 1'b0, 1'b1);
    applyStimulus(2'd1, 1'b0, 2'd0, 24'h800000, 24'h800001, 6'd3,  1'b0, 1'b0, 28'h4800001, 1'b0, 1'b1);
    applyStimulus(2'd2, 1'b0, 2'd0, 24'h800000, 24'hC00000, 6'd26, 1'b0, 1'b1, 28'h4000001, 1'b1, 1'b1);
    applyStimulus(2'd3, 1'b0, 2'd0, 24'h800000, 24'h000000, 6'd63, 1'b0, 1'b1, 28'h4000000, 1'b1, 1'b1);
    applyStimulus(2'd2, 1'b1, 2'd2, 24'h800000, 24'h800000, 6'd0,  1'b0, 1'b0, 28'h8000000, 1'b0, 1'b0);
    applyStimulus(2'd2, 1'b1, 2'd3, 24'h900000, 24'h100000, 6'd2,  1'b1, 1'b0, 28'h4600000, 1'b0, 1'b1);
    @(negedge clk);
    driveIdle();
    waitDrain();

    // Reset pulse while an instruction sits in mx2: control outputs must clear at once.
    applyStimulus(2'd1, 1'b0, 2'd0, 24'h800000, 24'h800000, 6'd0, 1'b0, 1'b0, 28'h8000000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("inflight_valid", 64'(mx2_instruction_valid), 64'd1);
    reset = 1'b1;
    driveIdle();
    #1;
    checkOutput("midreset_valid", 64'(mx2_instruction_valid), 64'd0);
    checkOutput("midreset_instruction", 64'(mx2_instruction), 64'd0);
    checkOutput("midreset_mask", 64'(mx2_mask_value), 64'd0);
    checkOutput("midreset_thread", 64'(mx2_thread_idx), 64'd0);
    checkOutput("midreset_subcycle", 64'(mx2_subcycle), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(2'd3, 1'b1, 2'd0, 24'hA00000, 24'h400000, 6'd1, 1'b1, 1'b1, 28'h4000000, 1'b1, 1'b1);
    @(negedge clk);
    driveIdle();
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
